// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the cache/memory line-port arbiter.
package mem_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    ICACHE,
    DCACHE
  } arb_src_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundles the icache, dcache and pmem line-port signals of the arbiter.
// slave is the arbiter's view; master is the caches/adaptor environment.
interface cache_mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned LINE_W = ARB_LINE_W
);

  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between icache and dcache requests.
// ARB_ROUND_ROBIN_EN: alternate on contention; otherwise dcache has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic     i_req_i,
  input  logic     d_req_i,
  input  arb_src_t last_grant_i,
  output arb_src_t winner_o,
  output logic     valid_o
);

  always_comb begin
    valid_o  = i_req_i | d_req_i;
    winner_o = DCACHE;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_req_i && d_req_i) begin
      winner_o = (last_grant_i == DCACHE) ? ICACHE : DCACHE;
    end else if (i_req_i) begin
      winner_o = ICACHE;
    end
`else
    if (i_req_i && !d_req_i) begin
      winner_o = ICACHE;
    end
`endif
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = (last_grant_i == DCACHE);
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one burst-memory line port between icache and dcache, one transaction at a time.
// Optional macro ARB_ROUND_ROBIN_EN replaces fixed dcache priority with round-robin.
module cache_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned LINE_W = ARB_LINE_W
)(
  input logic                clk,
  input logic                rst,
  cache_mem_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  logic              read_q,  read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  arb_src_t last_grant;
  arb_src_t winner;
  logic     win_valid;
  logic     d_req;

  assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
  arb_src_t last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;
`else
  assign last_grant = ICACHE;
`endif

  mem_arb_pick u_pick (
    .i_req_i      (bus.i_read),
    .d_req_i      (d_req),
    .last_grant_i (last_grant),
    .winner_o     (winner),
    .valid_o      (win_valid)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    bus.i_resp = 1'b0;
    bus.d_resp = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          if (winner == DCACHE) begin
            // A read+write collision is treated as a writeback.
            state_d = SERVE_D;
            read_d  = ~bus.d_write;
            write_d = bus.d_write;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
          end else begin
            state_d = SERVE_I;
            read_d  = 1'b1;
            write_d = 1'b0;
            addr_d  = bus.i_addr;
          end
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = winner;
`endif
        end
      end
      SERVE_I: begin
        if (bus.pmem_resp) begin
          bus.i_resp = 1'b1;
          state_d    = IDLE;
          read_d     = 1'b0;
          write_d    = 1'b0;
        end
      end
      SERVE_D: begin
        if (bus.pmem_resp) begin
          bus.d_resp = 1'b1;
          state_d    = IDLE;
          read_d     = 1'b0;
          write_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= ICACHE;
    else      last_grant_q <= last_grant_d;
  end
`endif

  // Downstream strobes come from flops only; read data is broadcast and qualified by resp.
  assign bus.pmem_read  = read_q;
  assign bus.pmem_write = write_q;
  assign bus.pmem_addr  = addr_q;
  assign bus.pmem_wdata = wdata_q;
  assign bus.i_rdata    = bus.pmem_rdata;
  assign bus.d_rdata    = bus.pmem_rdata;

  a_no_d_read_write: assert property (@(posedge clk) disable iff (!rst)
    !(bus.d_read && bus.d_write));

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single burst-memory line port (cacheline adaptor side) between the icache miss port and the dcache miss/writeback port.
- Sits between the two caches and the cacheline adaptor in the mp4 top level.
- Grants one line transaction at a time, registers the winning address/data, and routes the response back to the owner.
- Dcache has fixed priority by default.

Parameters:
- ADDR_W, 32, line address width (low 5 bits ignored downstream, passed through)
- LINE_W, 256, cache line width in bits

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- i_read  in  1  icache line read request
- i_addr  in  ADDR_W  icache line address
- i_rdata  out  LINE_W  line data to icache
- i_resp  out  1  icache transaction done
- d_read  in  1  dcache line read request
- d_write  in  1  dcache line writeback request
- d_addr  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  dcache writeback data
- d_rdata  out  LINE_W  line data to dcache
- d_resp  out  1  dcache transaction done
- pmem_read  out  1  downstream line read
- pmem_write  out  1  downstream line write
- pmem_addr  out  ADDR_W  downstream address
- pmem_wdata  out  LINE_W  downstream write data
- pmem_rdata  in  LINE_W  downstream read data
- pmem_resp  in  1  downstream done

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - pmem_read, pmem_write, i_resp and d_resp go to 0.
  - pmem_addr and pmem_wdata go to 0.
  - last_grant goes to ICACHE.
- Takes effect immediately, including mid-transaction. The adaptor is reset by the same signal, so no transaction resumes.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Samples requests every cycle.
  - If (d_read | d_write), the grant goes to D; else if i_read, the grant goes to I; else stay in IDLE.
  - On the grant edge, the arbiter latches the address, wdata and op (read or write) into registers and moves to SERVE_x.
- SERVE_x:
  - pmem_read/pmem_write/pmem_addr/pmem_wdata are driven from registers only. No combinational path from requester inputs to the pmem outputs.
  - Request seen in IDLE at cycle N means the pmem strobe is high from cycle N+1 until pmem_resp.
- Response:
  - In the cycle pmem_resp=1 while in SERVE_x, x_resp=1 combinationally in that same cycle, and x_rdata=pmem_rdata.
  - The other requester's resp stays 0.
  - Next edge: strobes drop and the FSM returns to IDLE.
- Rdata outputs:
  - i_rdata and d_rdata both mirror pmem_rdata at all times.
  - Only the matching resp qualifies the data.
- Requester rules:
  - A requester holds its request stable until its resp.
  - A request still asserted in the first IDLE cycle after resp counts as a new request.
  - Turnaround: one IDLE cycle between back-to-back transactions.
- Simultaneous i_read and d_read/d_write in IDLE: D wins (base build). I is served next, provided its request is still held.
- d_read and d_write both high: treated as a write. A simulation-only assertion flags the illegal combination.
- pmem_resp while in IDLE: ignored; no resp is forwarded and the state is unchanged.
- Requests that change while in SERVE_x have no effect; the latched values are used.
- Rdata and wdata are full LINE_W widths with no masking. The address passes through unmodified.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- When defined:
  - last_grant updates on every grant.
  - On a simultaneous I/D request in IDLE, the grant goes to the requester not in last_grant.
  - A single requester is always granted regardless of last_grant.
- When undefined: fixed dcache priority; the last_grant flop is removed.

Decomposition:
- Shared package mem_arb_pkg holds:
  - enum arb_state_t {IDLE, SERVE_I, SERVE_D}
  - enum arb_src_t {ICACHE, DCACHE}
  - localparams for default ADDR_W/LINE_W
- One sub-module, mem_arb_pick: purely combinational winner select (inputs are requests and last_grant, output is arb_src_t and a valid bit). It isolates the ARB_ROUND_ROBIN_EN logic.
- The FSM and registers live in the top.

Test Plan:
- I-only read: i_read=1, i_addr=0x0000_0060, pmem_resp after 4 cycles with rdata=0xA5..A5.
  - pmem_read rises 1 cycle after request, pmem_addr=0x60.
  - i_resp=1 for exactly 1 cycle with i_rdata=0xA5..A5; d_resp stays 0.
- Simultaneous: i_read (0x100) and d_write (0x200, wdata=0x1234...) raised in the same cycle.
  - Base build: pmem_write first with addr 0x200 and that wdata, then IDLE for 1 cycle, then pmem_read 0x100.
  - With ARB_ROUND_ROBIN_EN after a prior D grant: I is served first.
- Request changes mid-transaction: d_read at 0x300 is granted, then d_addr changes to 0x400 while waiting → pmem_addr stays 0x300 until pmem_resp.
- Reset mid-operation: rst=0 during SERVE_D between clock edges → pmem_read/pmem_write/d_resp fall immediately; after release the FSM is IDLE and a new i_read is granted normally.
- Spurious resp: pmem_resp=1 in IDLE with no requests → i_resp=d_resp=0, state remains IDLE.
- Back-to-back D: d_read held again the cycle after d_resp while i_read is also pending → base build grants D again (I starves); with ARB_ROUND_ROBIN_EN, I is granted.
